usb_buffer_arbiter: RTL and testbench
=====================================

USB_BUFFER_ARBITER -- requirements
Module: usb_buffer_arbiter

Interface
REQ-001 clk  input  1  system clock, all state updates on rising edge.
REQ-002 n_rst  input  1  reset, asynchronous, active-low.
REQ-003 clear  input  1  flush request from AHB register block, level, sampled every cycle.
REQ-004 ahb_store  input  1  AHB-side byte write request (store_tx_data), held until granted.
REQ-005 ahb_get  input  1  AHB-side byte read request (get_rx_data), held until granted.
REQ-006 ahb_wdata  input  8  AHB write byte.
REQ-007 rx_store  input  1  USB RX byte write request, held until granted.
REQ-008 rx_wdata  input  8  USB RX write byte.
REQ-009 tx_get  input  1  USB TX byte read request, held until granted.
REQ-010 buf_rdata  input  8  single-port 64x8 buffer read data, valid 1 cycle after buf_re.
REQ-011 buf_addr  output  6  buffer address (wr_ptr on write, rd_ptr on read).
REQ-012 buf_wdata  output  8  buffer write data.
REQ-013 buf_we  output  1  buffer write strobe.
REQ-014 buf_re  output  1  buffer read strobe.
REQ-015 ahb_gnt / rx_gnt / tx_gnt  output  1 each  combinational grant; request consumed in cycle of grant.
REQ-016 rd_data  output  8  registered copy of buf_rdata for the read owner.
REQ-017 ahb_rvalid / tx_rvalid  output  1 each  rd_data valid for that requester, 1-cycle pulse.
REQ-018 occupancy  output  7  bytes stored, 0..64.
REQ-019 overflow_err / underflow_err  output  1 each  1-cycle pulse on rejected access.
REQ-020 flushing  output  1  high while FSM in FLUSH.

Function
REQ-021 FSM states IDLE, ACCESS, FLUSH; IDLE->ACCESS on any request, ACCESS->IDLE when no request, any state->FLUSH when clear=1, FLUSH->IDLE after exactly one cycle if clear=0, else stays FLUSH.
REQ-022 At most one buffer access per cycle; exactly one grant or none.
REQ-023 Fixed priority (macro absent): rx_store > tx_get > ahb_store > ahb_get.
REQ-024 In FLUSH no grant issued; wr_ptr, rd_ptr, occupancy zeroed; pending requests held, not lost.
REQ-025 Granted write: buf_we=1, buf_addr=wr_ptr, buf_wdata=requester byte, wr_ptr+1 mod 64, occupancy+1.
REQ-026 Granted read: buf_re=1, buf_addr=rd_ptr, rd_ptr+1 mod 64, occupancy-1; next cycle rd_data=buf_rdata and owner's rvalid=1.
REQ-027 Pointers wrap 63->0 with no gap; occupancy never exceeds 64 nor goes below 0.
REQ-028 Write with occupancy=64: grant given, no buf_we, no pointer/count change, overflow_err pulses next cycle.
REQ-029 Read with occupancy=0: grant given, no buf_re, no rvalid, underflow_err pulses next cycle.
REQ-030 Read and write requests in the same cycle: only winner proceeds; occupancy changes by exactly +/-1.
REQ-031 clear arriving in the same cycle as a read grant suppresses that grant; no rvalid follows.
REQ-032 Idle outputs: buf_we, buf_re, all grants, rvalids, error pulses = 0; buf_addr=rd_ptr.

Reset
REQ-033 n_rst low: FSM=IDLE, wr_ptr=rd_ptr=0, occupancy=0, rd_data=0x00, rvalids, error pulses, flushing=0, immediately and asynchronously.
REQ-034 Reset mid-read cancels the pending rvalid; first post-reset cycle behaves as IDLE with empty buffer.

Configuration
REQ-035 USB_BUF_ARB_RR_EN defined: USB side (rx_store/tx_get, internal order rx first) and AHB side (ahb_store/ahb_get, store first) alternate round-robin, last-served side loses ties.
REQ-036 USB_BUF_ARB_RR_EN undefined: fixed priority of REQ-023; no round-robin state register present.

Verification
REQ-037 Reset, 64 rx_store writes 0x00..0x3F -> occupancy=64, wr_ptr wrapped to 0; 65th write -> overflow_err pulse, occupancy stays 64.
REQ-038 From full, 64 ahb_get reads -> ahb_rvalid each 1 cycle after grant, data 0x00..0x3F in order; 65th -> underflow_err, no rvalid.
REQ-039 rx_store and ahb_get asserted together, occupancy=5 (macro absent) -> rx_gnt first, ahb_gnt next cycle, occupancy 6 then 5.
REQ-040 Occupancy=10, clear pulsed 1 cycle while tx_get held -> flushing=1 one cycle, occupancy=0, then tx_get -> underflow_err.
REQ-041 USB_BUF_ARB_RR_EN defined, rx_store and ahb_store held 4 cycles -> grants alternate rx, ahb, rx, ahb.
REQ-042 n_rst asserted one cycle after a tx_get grant -> no tx_rvalid, occupancy=0, pointers=0.

Source files
------------

// File: rtl/usb_buffer_arbiter.sv
// Arbitrates USB RX/TX and AHB byte accesses onto a single-port 64x8 buffer with flush support.
// Optional round-robin USB/AHB arbitration is enabled by defining USB_BUF_ARB_RR_EN.
module usb_buffer_arbiter (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       clear,
   input  logic       ahb_store,
   input  logic       ahb_get,
   input  logic [7:0] ahb_wdata,
   input  logic       rx_store,
   input  logic [7:0] rx_wdata,
   input  logic       tx_get,
   input  logic [7:0] buf_rdata,
   output logic [5:0] buf_addr,
   output logic [7:0] buf_wdata,
   output logic       buf_we,
   output logic       buf_re,
   output logic       ahb_gnt,
   output logic       rx_gnt,
   output logic       tx_gnt,
   output logic [7:0] rd_data,
   output logic       ahb_rvalid,
   output logic       tx_rvalid,
   output logic [6:0] occupancy,
   output logic       overflow_err,
   output logic       underflow_err,
   output logic       flushing
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [6:0] occ_q, occ_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       ahb_rvalid_q, ahb_rvalid_d, tx_rvalid_q, tx_rvalid_d;
   logic       ovf_q, ovf_d, unf_q, unf_d;
   logic       sel_rx, sel_tx, sel_as, sel_ag;
   logic       any_req, blocked, wr_req, rd_req, full, empty;
`ifdef USB_BUF_ARB_RR_EN
   logic       rr_ahb_last_q, rr_ahb_last_d;
   logic       usb_req, ahb_req;
`endif

   assign any_req = rx_store | tx_get | ahb_store | ahb_get;
   assign blocked = clear | (state_q == ST_FLUSH);
   assign full    = (occ_q == 7'd64);
   assign empty   = (occ_q == 7'd0);

   // Grant selection: a clear or an active flush suppresses every grant.
   always_comb begin
      sel_rx = 1'b0;
      sel_tx = 1'b0;
      sel_as = 1'b0;
      sel_ag = 1'b0;
`ifdef USB_BUF_ARB_RR_EN
      usb_req       = rx_store | tx_get;
      ahb_req       = ahb_store | ahb_get;
      rr_ahb_last_d = rr_ahb_last_q;
      if (blocked) begin
         sel_rx = 1'b0;
      end else if (usb_req && (!ahb_req || rr_ahb_last_q)) begin
         sel_rx        = rx_store;
         sel_tx        = !rx_store && tx_get;
         rr_ahb_last_d = 1'b0;
      end else if (ahb_req) begin
         sel_as        = ahb_store;
         sel_ag        = !ahb_store && ahb_get;
         rr_ahb_last_d = 1'b1;
      end else begin
         rr_ahb_last_d = rr_ahb_last_q;
      end
`else
      if (blocked)        sel_rx = 1'b0;
      else if (rx_store)  sel_rx = 1'b1;
      else if (tx_get)    sel_tx = 1'b1;
      else if (ahb_store) sel_as = 1'b1;
      else if (ahb_get)   sel_ag = 1'b1;
      else                sel_rx = 1'b0;
`endif
   end

   assign rx_gnt  = sel_rx;
   assign tx_gnt  = sel_tx;
   assign ahb_gnt = sel_as | sel_ag;
   assign wr_req  = sel_rx | sel_as;
   assign rd_req  = sel_tx | sel_ag;

   // Buffer port, pointer/occupancy update and next-cycle pulses.
   always_comb begin
      buf_we       = wr_req && !full;
      buf_re       = rd_req && !empty;
      buf_addr     = wr_req ? wr_ptr_q : rd_ptr_q;
      buf_wdata    = sel_rx ? rx_wdata : (sel_as ? ahb_wdata : 8'h00);
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      occ_d        = occ_q;
      ovf_d        = wr_req && full;
      unf_d        = rd_req && empty;
      tx_rvalid_d  = sel_tx && !empty;
      ahb_rvalid_d = sel_ag && !empty;
      // rd_data forwards the buffer during the rvalid cycle and holds it afterwards.
      rd_data_d    = (ahb_rvalid_q || tx_rvalid_q) ? buf_rdata : rd_data_q;
      if (blocked) begin
         wr_ptr_d = 6'd0;
         rd_ptr_d = 6'd0;
         occ_d    = 7'd0;
      end else if (buf_we) begin
         wr_ptr_d = wr_ptr_q + 6'd1;
         occ_d    = occ_q + 7'd1;
      end else if (buf_re) begin
         rd_ptr_d = rd_ptr_q + 6'd1;
         occ_d    = occ_q - 7'd1;
      end else begin
         occ_d    = occ_q;
      end
   end

   // Next-state logic for IDLE/ACCESS/FLUSH.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_FLUSH;
      end else begin
         case (state_q)
            ST_IDLE:   state_d = any_req ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_d = any_req ? ST_ACCESS : ST_IDLE;
            ST_FLUSH:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= 6'd0;
         rd_ptr_q     <= 6'd0;
         occ_q        <= 7'd0;
         rd_data_q    <= 8'h00;
         ahb_rvalid_q <= 1'b0;
         tx_rvalid_q  <= 1'b0;
         ovf_q        <= 1'b0;
         unf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
         rd_data_q    <= rd_data_d;
         ahb_rvalid_q <= ahb_rvalid_d;
         tx_rvalid_q  <= tx_rvalid_d;
         ovf_q        <= ovf_d;
         unf_q        <= unf_d;
      end
   end

`ifdef USB_BUF_ARB_RR_EN
   // Last-served side; AHB counts as last after reset so USB wins the first tie.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) rr_ahb_last_q <= 1'b1;
      else        rr_ahb_last_q <= rr_ahb_last_d;
   end
`endif

   assign rd_data       = (ahb_rvalid_q || tx_rvalid_q) ? buf_rdata : rd_data_q;
   assign ahb_rvalid    = ahb_rvalid_q;
   assign tx_rvalid     = tx_rvalid_q;
   assign occupancy     = occ_q;
   assign overflow_err  = ovf_q;
   assign underflow_err = unf_q;
   assign flushing      = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Randomized self-checking bench for usb_buffer_arbiter against a queue-based reference model.
module tb_usb_buffer_arbiter;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       clear = 1'b0, ahb_store = 1'b0, ahb_get = 1'b0, rx_store = 1'b0, tx_get = 1'b0;
   logic [7:0] ahb_wdata = 8'h00, rx_wdata = 8'h00, buf_rdata, buf_wdata, rd_data;
   logic [5:0] buf_addr;
   logic       buf_we, buf_re, ahb_gnt, rx_gnt, tx_gnt, ahb_rvalid, tx_rvalid;
   logic       overflow_err, underflow_err, flushing;
   logic [6:0] occupancy;

   logic [7:0] mem [64];
   logic [7:0] rdata_q = 8'h00;

   int checks = 0;
   int errors = 0;

   // reference model: byte FIFO, write/read counts since last flush, flush flag, RR side
   logic [7:0] q[$];
   int  m_wp, m_rp, m_w;
   bit  m_flush, m_last_ahb;

   logic [4:0]  e_pre, o_pre;    // {rx_gnt, tx_gnt, ahb_gnt, buf_we, buf_re}
   logic [11:0] e_post, o_post;  // {ahb_rvalid, tx_rvalid, ovf, unf, flushing, occupancy}
   logic [5:0]  e_addr, o_addr;
   logic [7:0]  e_data, o_data;

   always #5 clk = ~clk;

   usb_buffer_arbiter dut (
      .clk(clk), .n_rst(n_rst), .clear(clear), .ahb_store(ahb_store), .ahb_get(ahb_get),
      .ahb_wdata(ahb_wdata), .rx_store(rx_store), .rx_wdata(rx_wdata), .tx_get(tx_get),
      .buf_rdata(buf_rdata), .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we),
      .buf_re(buf_re), .ahb_gnt(ahb_gnt), .rx_gnt(rx_gnt), .tx_gnt(tx_gnt), .rd_data(rd_data),
      .ahb_rvalid(ahb_rvalid), .tx_rvalid(tx_rvalid), .occupancy(occupancy),
      .overflow_err(overflow_err), .underflow_err(underflow_err), .flushing(flushing)
   );

   // external single-port buffer with one-cycle read latency
   always @(posedge clk) begin
      if (buf_we) mem[buf_addr] <= buf_wdata;
      if (buf_re) rdata_q <= mem[buf_addr];
   end
   assign buf_rdata = rdata_q;

   // winner index: 0 rx_store, 1 tx_get, 2 ahb_store, 3 ahb_get, -1 none
   function automatic int pick(bit rs, bit tg, bit as, bit ag);
`ifdef USB_BUF_ARB_RR_EN
      if ((rs || tg) && (!(as || ag) || m_last_ahb)) return rs ? 0 : 1;
      if (as || ag) return as ? 2 : 3;
      return -1;
`else
      if (rs) return 0;
      if (tg) return 1;
      if (as) return 2;
      if (ag) return 3;
      return -1;
`endif
   endfunction

   task automatic model_reset();
      q.delete();
      m_wp = 0; m_rp = 0; m_flush = 1'b0; m_last_ahb = 1'b1;
   endtask

   // one clock cycle of stimulus; fills e_* from the model and o_* from the DUT
   task automatic step(input bit c, input bit rs, input bit tg, input bit as, input bit ag,
                       input logic [7:0] rw, input logic [7:0] aw);
      bit ovf = 1'b0, unf = 1'b0, rva = 1'b0, rvt = 1'b0, we = 1'b0, re = 1'b0;
      @(negedge clk);
      clear = c; rx_store = rs; tx_get = tg; ahb_store = as; ahb_get = ag;
      rx_wdata = rw; ahb_wdata = aw;
      m_w = (c || m_flush) ? -1 : pick(rs, tg, as, ag);
      e_addr = (m_w == 0 || m_w == 2) ? m_wp[5:0] : m_rp[5:0];
      if (m_w == 0 || m_w == 2) begin
         if (q.size() < 64) begin
            we = 1'b1; q.push_back(m_w == 0 ? rw : aw); m_wp = (m_wp + 1) % 64;
         end else ovf = 1'b1;
      end else if (m_w == 1 || m_w == 3) begin
         if (q.size() > 0) begin
            re = 1'b1; e_data = q.pop_front(); m_rp = (m_rp + 1) % 64;
            if (m_w == 1) rvt = 1'b1; else rva = 1'b1;
         end else unf = 1'b1;
      end
      if (m_w >= 0) m_last_ahb = (m_w >= 2);
      if (c) begin q.delete(); m_wp = 0; m_rp = 0; end
      m_flush = c;
      e_pre  = {m_w == 0, m_w == 1, m_w >= 2, we, re};
      e_post = {rva, rvt, ovf, unf, c, 7'(q.size())};
      #2;
      o_pre  = {rx_gnt, tx_gnt, ahb_gnt, buf_we, buf_re};
      o_addr = buf_addr;
      @(posedge clk);
      #1;
      o_post = {ahb_rvalid, tx_rvalid, overflow_err, underflow_err, flushing, occupancy};
      o_data = rd_data;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      checks++;
      if ({ahb_rvalid, tx_rvalid, overflow_err, underflow_err, flushing, occupancy, rd_data, buf_addr} !== 27'd0) begin
         errors++;
         $display("FAIL reset_state: got rv=%b%b err=%b%b fl=%b occ=%0d rd=%h addr=%0d, expected all zero",
                  ahb_rvalid, tx_rvalid, overflow_err, underflow_err, flushing, occupancy, rd_data, buf_addr);
      end
      model_reset();
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 65; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(i), 8'h00);
         checks++;
         if (o_pre !== e_pre || o_addr !== e_addr || o_post !== e_post) begin
            errors++;
            $display("FAIL fill_%0d: got pre=%b addr=%0d post=%h, expected pre=%b addr=%0d post=%h",
                     i, o_pre, o_addr, o_post, e_pre, e_addr, e_post);
         end
      end
      checks++;
      if (o_post !== {4'b0010, 1'b0, 7'd64}) begin
         errors++;
         $display("FAIL overflow_65th: got post=%h, expected overflow with occupancy 64", o_post);
      end
   endtask

   task automatic test_drain_underflow();
      for (int i = 0; i < 65; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
         checks++;
         if (o_pre !== e_pre || o_addr !== e_addr || o_post !== e_post ||
             (e_post[11] && (o_data !== e_data || o_data !== 8'(i)))) begin
            errors++;
            $display("FAIL drain_%0d: got pre=%b addr=%0d post=%h data=%h, expected pre=%b addr=%0d post=%h data=%h",
                     i, o_pre, o_addr, o_post, o_data, e_pre, e_addr, e_post, e_data);
         end
      end
      checks++;
      if (o_post !== 12'h100) begin
         errors++;
         $display("FAIL underflow_65th: got post=%h, expected underflow only", o_post);
      end
   endtask

   task automatic test_arbitration();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h50 + 8'(i), 8'h00);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h00);
      checks++;
      if (o_pre !== e_pre || o_post !== e_post) begin
         errors++;
         $display("FAIL contend_first: got pre=%b post=%h, expected pre=%b post=%h", o_pre, o_post, e_pre, e_post);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      checks++;
      if (o_pre !== e_pre || o_post !== e_post || o_data !== e_data) begin
         errors++;
         $display("FAIL contend_second: got pre=%b post=%h data=%h, expected pre=%b post=%h data=%h",
                  o_pre, o_post, o_data, e_pre, e_post, e_data);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10 + 8'(i), 8'h20 + 8'(i));
         checks++;
         if (o_pre !== e_pre || o_post !== e_post) begin
            errors++;
            $display("FAIL store_tie_%0d: got pre=%b post=%h, expected pre=%b post=%h", i, o_pre, o_post, e_pre, e_post);
         end
      end
   endtask

   task automatic test_flush();
      while (q.size() < 10) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 8'h00);
      for (int i = 0; i < 3; i++) begin
         step(i == 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
         checks++;
         if (o_pre !== e_pre || o_post !== e_post) begin
            errors++;
            $display("FAIL flush_%0d: got pre=%b post=%h, expected pre=%b post=%h", i, o_pre, o_post, e_pre, e_post);
         end
      end
      checks++;
      if (o_post !== 12'h100) begin
         errors++;
         $display("FAIL flush_then_get: got post=%h, expected underflow with occupancy 0", o_post);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 8'h00);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      checks++;
      if (o_pre !== 5'b0 || o_post !== 12'h080) begin
         errors++;
         $display("FAIL clear_with_read: got pre=%b post=%h, expected no grant, no rvalid, flushing", o_pre, o_post);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic test_random();
      bit prs = 0, ptg = 0, pas = 0, pag = 0;
      logic [7:0] rw = 8'h00, aw = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if (!prs && $urandom_range(0, 2) == 0) begin prs = 1; rw = 8'($urandom); end
         if (!ptg && $urandom_range(0, 3) == 0) ptg = 1;
         if (!pas && $urandom_range(0, 2) == 0) begin pas = 1; aw = 8'($urandom); end
         if (!pag && $urandom_range(0, 3) == 0) pag = 1;
         step($urandom_range(0, 29) == 0, prs, ptg, pas, pag, rw, aw);
         checks++;
         if (o_pre !== e_pre || o_post !== e_post || ((e_pre[0] | e_pre[1]) && o_addr !== e_addr) ||
             ((e_post[11] | e_post[10]) && o_data !== e_data)) begin
            errors++;
            $display("FAIL random_%0d: got pre=%b addr=%0d post=%h data=%h, expected pre=%b addr=%0d post=%h data=%h",
                     i, o_pre, o_addr, o_post, o_data, e_pre, e_addr, e_post, e_data);
         end
         case (m_w)
            0: prs = 0;
            1: ptg = 0;
            2: pas = 0;
            3: pag = 0;
            default: ;
         endcase
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic test_reset_midread();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h70 + 8'(i), 8'h00);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      n_rst = 1'b0;
      #1;
      checks++;
      if (tx_rvalid !== 1'b0 || occupancy !== 7'd0 || buf_addr !== 6'd0) begin
         errors++;
         $display("FAIL reset_midread: got tx_rvalid=%b occ=%0d addr=%0d, expected 0 0 0", tx_rvalid, occupancy, buf_addr);
      end
      model_reset();
      @(negedge clk);
      n_rst = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      checks++;
      if (o_pre !== 5'b0 || o_post !== 12'h000 || o_addr !== 6'd0) begin
         errors++;
         $display("FAIL post_reset_idle: got pre=%b post=%h addr=%0d, expected all zero", o_pre, o_post, o_addr);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fill_overflow();
      test_drain_underflow();
      test_arbitration();
      test_flush();
      test_random();
      test_reset_midread();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
